// File: rtl/itu656_line_decoder_if.sv
// Decoded BT.656 pixel bus: one {Y,C} word per strobe with position, field and sync status.
interface itu656_line_decoder_if;
  logic [15:0] oYCbCr;
  logic        oDVAL;
  logic [9:0]  oTV_X;
  logic [9:0]  oTV_Y;
  logic        oField;
  logic        oSync_Err;

  modport master (output oYCbCr, oDVAL, oTV_X, oTV_Y, oField, oSync_Err);
  modport slave  (input  oYCbCr, oDVAL, oTV_X, oTV_Y, oField, oSync_Err);
endinterface

// File: rtl/itu656_line_decoder.sv
// BT.656 byte stream to 4:2:2 pixel decoder with FF 00 00 XY timing-reference tracking.
//   state  | meaning
//   SEARCH | no valid timing reference seen since reset or loss of stable
//   BLANK  | between EAV and SAV, or vertical blanking line
//   ACTIVE | assembling Cb Y0 Cr Y1 pixels of an active line
module itu656_line_decoder #(
  parameter int ACT_PIX     = 720,
  parameter bit CHECK_PROT  = 1'b1,
  parameter int SYNC_STAGES = 2
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic [7:0] iTD_DATA,
  input  logic       iTD_Stable,
  itu656_line_decoder_if.master vid
);

  typedef enum logic [1:0] {SEARCH, BLANK, ACTIVE} state_t;

  localparam logic [9:0] ACT_MAX = 10'(ACT_PIX);

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   stb;
  logic [7:0]             cur;
  logic [23:0]            win;
  logic [1:0]             phase;
  logic [9:0]             x;
  logic [7:0]             c;
  logic                   line_pix;
  logic [15:0]            ycbcr;
  logic                   dval;
  logic [9:0]             tv_x;
  logic [9:0]             tv_y;
  logic                   field;
  logic                   sync_err;
  logic                   hit, f, v, h, prot_ok, xy_ok;

  // Input byte is registered first, so win holds the three bytes before cur.
  assign stb     = sync_q[SYNC_STAGES-1];
  assign hit     = (win == 24'hFF_0000);
  assign f       = cur[6];
  assign v       = cur[5];
  assign h       = cur[4];
  assign prot_ok = cur[7] && (cur[3:0] == {v ^ h, f ^ h, f ^ v, f ^ v ^ h});
  assign xy_ok   = prot_ok || !CHECK_PROT;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state    <= SEARCH;
      sync_q   <= '0;
      cur      <= 8'h00;
      win      <= 24'h0;
      phase    <= 2'd0;
      x        <= 10'd0;
      c        <= 8'h00;
      line_pix <= 1'b0;
      ycbcr    <= 16'h0;
      dval     <= 1'b0;
      tv_x     <= 10'd0;
      tv_y     <= 10'd0;
      field    <= 1'b0;
      sync_err <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], iTD_Stable};
      cur      <= iTD_DATA;
      win      <= {win[15:0], cur};
      dval     <= 1'b0;
      sync_err <= 1'b0;
      if (!stb) begin
        state    <= SEARCH;
        phase    <= 2'd0;
        x        <= 10'd0;
        line_pix <= 1'b0;
      end else if (hit && !xy_ok) begin
        sync_err <= 1'b1;
      end else if (hit) begin
        if (h) begin
          state    <= BLANK;
          line_pix <= 1'b0;
          if (line_pix) tv_y <= tv_y + 10'd1;
        end else if (v) begin
          state    <= BLANK;
          line_pix <= 1'b0;
          tv_y     <= 10'd0;
        end else begin
          state    <= ACTIVE;
          field    <= f;
          x        <= 10'd0;
          phase    <= 2'd0;
          line_pix <= 1'b0;
        end
      end else if (state == ACTIVE) begin
        // FF can only be the start of EAV here; any half-built pixel is abandoned.
        if (cur == 8'hFF) begin
          state <= BLANK;
        end else begin
          phase <= phase + 2'd1;
          if (!phase[0]) begin
            c <= cur;
          end else if (x < ACT_MAX) begin
            dval     <= 1'b1;
            ycbcr    <= {cur, c};
            tv_x     <= x;
            x        <= x + 10'd1;
            line_pix <= 1'b1;
          end
        end
      end
    end
  end

  assign vid.oYCbCr    = ycbcr;
  assign vid.oDVAL     = dval;
  assign vid.oTV_X     = tv_x;
  assign vid.oTV_Y     = tv_y;
  assign vid.oField    = field;
  assign vid.oSync_Err = sync_err;

endmodule
